wb_bus_arbiter: RTL
===================

WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8'd255: bus-timeout limit in clk_p cycles, range 2..255.
REQ-002 clk_p  in  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cpu_cyc_i  in  1  CPU Wishbone cycle strobe.
REQ-005 cpu_gnt_o  out  1  bus grant to CPU; drives the CPU's gnt input.
REQ-006 dma_req_i  in  2  bus requests, one bit per DMA master.
REQ-007 dma_cyc_i  in  2  Wishbone cycle strobes, one per DMA master.
REQ-008 dma_gnt_o  out  2  bus grants, one per DMA master; one-hot or zero.
REQ-009 bus_ack_i  in  1  global ack from memory and I/O page.
REQ-010 tmo_ack_o  out  1  injected ack on timeout; 1-cycle pulse, ORed into the owner's ack externally.
REQ-011 tmo_o  out  1  sticky timeout flag.
REQ-012 tmo_clr_i  in  1  clears tmo_o.
REQ-013 bus_owner_o  out  2  current owner: 00 CPU, 01 DMA0, 10 DMA1, 11 none (gap).

Function
REQ-014 FSM states SHALL be: CPU, DMA0, DMA1, GAP; all outputs registered.
REQ-015 In CPU: cpu_gnt_o=1, dma_gnt_o=00.
REQ-016 CPU -> DMAx SHALL occur only when |dma_req_i=1 and cpu_cyc_i=0 on the same edge. No preemption while cpu_cyc_i=1.
REQ-017 On CPU -> DMAx, cpu_gnt_o SHALL fall and dma_gnt_o[x] SHALL rise on the same edge. Latency from the qualifying edge is 1 cycle.
REQ-018 DMA selection: a single requester wins. If both request, the winner is the master not in last_dma; last_dma updates to the winner on entry.
REQ-019 DMAx -> GAP SHALL occur when dma_req_i[x]=0 and dma_cyc_i[x]=0.
REQ-020 GAP SHALL last exactly 1 cycle with all grants 0, then go unconditionally to CPU. The CPU therefore holds the grant at least 1 cycle between DMA tenures.
REQ-021 Requests from a master not currently granted SHALL be held pending; requests are level-sensitive and not latched.
REQ-022 owner_cyc SHALL be cpu_cyc_i in CPU, dma_cyc_i[x] in DMAx, and 0 in GAP.
REQ-023 Timeout counter (8 bit): increments while owner_cyc=1 and bus_ack_i=0; clears when owner_cyc=0, bus_ack_i=1, or the state changes.
REQ-024 When the counter reaches TIMEOUT-1 with owner_cyc=1 and bus_ack_i=0:
- tmo_ack_o=1 on the next cycle;
- tmo_o set;
- counter clears.
REQ-025 bus_ack_i and the timeout condition in the same cycle: the ack wins, with no tmo_ack_o.
REQ-026 tmo_clr_i and a new timeout in the same cycle: set wins.

Reset
REQ-027 rst_n=0 SHALL asynchronously force:
- state CPU, cpu_gnt_o=1, dma_gnt_o=00, bus_owner_o=00;
- tmo_ack_o=0, tmo_o=0, counter=0, last_dma=1 (DMA0 wins the first tie).
REQ-028 Reset asserted mid-DMA tenure SHALL drop the DMA grant immediately (combinationally via async clear), with no GAP cycle.

Configuration
REQ-029 Macro WB_BUS_ARBITER_TIMEOUT_EN:
- defined: REQ-023..REQ-026 are implemented.
- undefined: counter logic is absent, and tmo_ack_o and tmo_o are tied to 0.
- Arbitration behaviour is identical in both builds.

Verification
REQ-030 Tie: reset, dma_req_i=11, cpu_cyc_i=0 ->
- DMA0 granted 1 cycle later;
- after DMA0 releases: GAP 1 cycle, then CPU;
- DMA1 granted next, with bus_owner_o sequence 01,11,00,10.
REQ-031 No preemption: cpu_cyc_i=1 for 5 cycles, dma_req_i=01 from cycle 0 -> cpu_gnt_o stays 1 until the edge after cpu_cyc_i falls; dma_gnt_o=01 on that same edge.
REQ-032 Timeout: TIMEOUT=4, CPU cyc=1, no ack -> tmo_ack_o pulses exactly 1 cycle on the 5th cycle and tmo_o=1; tmo_clr_i=1 -> tmo_o=0 next cycle.
REQ-033 Ack race: bus_ack_i=1 on the cycle the counter hits TIMEOUT-1 -> no tmo_ack_o and tmo_o stays 0.
REQ-034 Reset mid-tenure: rst_n=0 while dma_gnt_o=10 -> immediately dma_gnt_o=00 and cpu_gnt_o=1; after release, the tie goes to DMA0.
REQ-035 Build without WB_BUS_ARBITER_TIMEOUT_EN, rerun REQ-032 stimulus -> tmo_ack_o=0 and tmo_o=0 throughout; grants unchanged.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter
//   Arbitrates a shared Wishbone bus between one CPU (the default owner) and
//   two DMA masters. The CPU keeps the bus while cpu_cyc_i is high. An idle
//   CPU hands the bus to a requesting DMA master. Every DMA tenure ends with
//   a one-cycle GAP in which nobody is granted, and the bus then returns to
//   the CPU. When both DMA masters request together, they alternate.
//
//   Optional bus timeout, enabled by defining WB_BUS_ARBITER_TIMEOUT_EN.
//   The current owner may hold its cycle strobe for TIMEOUT clocks with no
//   ack. When that happens, a one-cycle ack is injected (tmo_ack_o) and the
//   sticky flag tmo_o is set. If the macro is not defined, the counter is
//   left out and both timeout outputs are tied low.
//
// Parameters
//   TIMEOUT      bus-timeout limit in clk_p cycles (2..255)
// Ports
//   clk_p        system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cpu_cyc_i    CPU Wishbone cycle strobe
//   cpu_gnt_o    bus grant to the CPU
//   dma_req_i    bus requests, one bit per DMA master
//   dma_cyc_i    cycle strobes, one bit per DMA master
//   dma_gnt_o    DMA grants, one-hot or zero
//   bus_ack_i    global ack from memory / I/O
//   tmo_ack_o    injected ack on timeout (1-cycle pulse)
//   tmo_o        sticky timeout flag
//   tmo_clr_i    clears tmo_o
//   bus_owner_o  00 CPU, 01 DMA0, 10 DMA1, 11 none (gap)
// ---------------------------------------------------------------------------
module wb_bus_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic       clk_p,
  input  logic       rst_n,
  input  logic       cpu_cyc_i,
  output logic       cpu_gnt_o,
  input  logic [1:0] dma_req_i,
  input  logic [1:0] dma_cyc_i,
  output logic [1:0] dma_gnt_o,
  input  logic       bus_ack_i,
  output logic       tmo_ack_o,
  output logic       tmo_o,
  input  logic       tmo_clr_i,
  output logic [1:0] bus_owner_o
);

  // The state encoding is the bus_owner_o code, so the state register drives
  // that output directly.
  typedef enum logic [1:0] {
    ST_CPU  = 2'b00,
    ST_DMA0 = 2'b01,
    ST_DMA1 = 2'b10,
    ST_GAP  = 2'b11
  } state_t;

  state_t     r_state;
  logic       r_cpu_gnt;
  logic [1:0] r_dma_gnt;
  logic       r_last_dma;   // 0: DMA0 won last tie-capable entry, 1: DMA1
  logic       w_leave;      // current state is left on this edge
  logic       w_pick_dma1;

  always_comb begin
    // NOTE: default assignment first so no path leaves w_leave unassigned;
    // that keeps this block purely combinational (no latch).
    w_leave = 1'b0;
    case (r_state)
      ST_CPU:  w_leave = (|dma_req_i) && !cpu_cyc_i;
      ST_DMA0: w_leave = !dma_req_i[0] && !dma_cyc_i[0];
      ST_DMA1: w_leave = !dma_req_i[1] && !dma_cyc_i[1];
      default: w_leave = 1'b1;  // GAP always lasts one cycle
    endcase
  end

  // A lone requester wins. On a tie, the master that did not win last time wins.
  assign w_pick_dma1 = (dma_req_i == 2'b10) ||
                       ((dma_req_i == 2'b11) && !r_last_dma);

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CPU;
      r_cpu_gnt  <= 1'b1;
      r_dma_gnt  <= 2'b00;
      r_last_dma <= 1'b1;   // DMA0 wins the first tie
    end else begin
      // NOTE: non-blocking assignments for all state so every register here
      // samples the pre-edge values, whatever order the statements are in.
      case (r_state)
        ST_CPU: begin
          if (w_leave) begin
            r_cpu_gnt <= 1'b0;
            if (w_pick_dma1) begin
              r_state    <= ST_DMA1;
              r_dma_gnt  <= 2'b10;
              r_last_dma <= 1'b1;
            end else begin
              r_state    <= ST_DMA0;
              r_dma_gnt  <= 2'b01;
              r_last_dma <= 1'b0;
            end
          end
        end
        ST_DMA0, ST_DMA1: begin
          if (w_leave) begin
            r_state   <= ST_GAP;
            r_dma_gnt <= 2'b00;
          end
        end
        default: begin
          r_state   <= ST_CPU;
          r_cpu_gnt <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_gnt_o   = r_cpu_gnt;
  assign dma_gnt_o   = r_dma_gnt;
  assign bus_owner_o = r_state;

`ifdef WB_BUS_ARBITER_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       r_tmo_ack;
  logic       r_tmo;
  logic       w_owner_cyc;
  logic       w_tmo_hit;

  always_comb begin
    w_owner_cyc = 1'b0;
    case (r_state)
      ST_CPU:  w_owner_cyc = cpu_cyc_i;
      ST_DMA0: w_owner_cyc = dma_cyc_i[0];
      ST_DMA1: w_owner_cyc = dma_cyc_i[1];
      default: w_owner_cyc = 1'b0;
    endcase
  end

  // A real ack in the same cycle as the limit wins, so there is no injection.
  assign w_tmo_hit = w_owner_cyc && !bus_ack_i && !w_leave &&
                     (r_tmo_cnt == TIMEOUT - 8'd1);

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= 8'd0;
      r_tmo_ack <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_tmo_ack <= w_tmo_hit;
      if (!w_owner_cyc || bus_ack_i || w_leave || w_tmo_hit)
        r_tmo_cnt <= 8'd0;
      else
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      // A new timeout takes priority over a clear in the same cycle.
      if (w_tmo_hit)
        r_tmo <= 1'b1;
      else if (tmo_clr_i)
        r_tmo <= 1'b0;
    end
  end

  assign tmo_ack_o = r_tmo_ack;
  assign tmo_o     = r_tmo;
`else
  // Without the timeout feature, the ack and clear inputs have no consumer.
  logic w_unused;
  assign w_unused  = bus_ack_i ^ tmo_clr_i;
  assign tmo_ack_o = 1'b0;
  assign tmo_o     = 1'b0;
`endif

endmodule
